// File: rtl/enemy_pkg.sv
// enemy_pkg: shared widths, constants, FSM state and slot record for the enemy slot scheduler
package enemy_pkg;
  localparam int SLOT_W = 3;
  localparam int ANGLE_W = 4;
  localparam int TYPE_W = 2;
  localparam int POS_W = 10;
  localparam int E_SIZE = 36;
  localparam int ANGLE_AMOUNT = 16;
  localparam int TYPE_AMOUNT = 4;
  typedef enum logic {IDLE, UPDATE} state_t;
  typedef struct packed {
    logic active;
    logic [TYPE_W-1:0] typ;
    logic [ANGLE_W-1:0] angle;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } slot_t;
endpackage

// File: rtl/enemy_slot_scheduler_if.sv
// enemy_slot_scheduler_if: spawn/kill/frame inputs and flattened per-slot renderer outputs
interface enemy_slot_scheduler_if #(parameter int SLOTS = 6);
  import enemy_pkg::*;
  logic frame_tick;
  logic spawn_valid;
  logic spawn_ready;
  logic [TYPE_W-1:0] spawn_type;
  logic [ANGLE_W-1:0] spawn_angle;
  logic [POS_W-1:0] spawn_x;
  logic [POS_W-1:0] spawn_y;
  logic kill_valid;
  logic [SLOT_W-1:0] kill_slot;
  logic [SLOTS-1:0] slot_active;
  logic [TYPE_W*SLOTS-1:0] slot_type;
  logic [ANGLE_W*SLOTS-1:0] slot_angle;
  logic [POS_W*SLOTS-1:0] slot_x;
  logic [POS_W*SLOTS-1:0] slot_y;
  logic escape_pulse;
  logic [SLOT_W-1:0] escape_slot;
  modport master (
    output frame_tick, spawn_valid, spawn_type, spawn_angle, spawn_x, spawn_y, kill_valid, kill_slot,
    input spawn_ready, slot_active, slot_type, slot_angle, slot_x, slot_y, escape_pulse, escape_slot
  );
  modport slave (
    input frame_tick, spawn_valid, spawn_type, spawn_angle, spawn_x, spawn_y, kill_valid, kill_slot,
    output spawn_ready, slot_active, slot_type, slot_angle, slot_x, slot_y, escape_pulse, escape_slot
  );
endinterface

// File: rtl/enemy_free_slot_finder.sv
// enemy_free_slot_finder: lowest-index inactive slot and whether any slot is free
module enemy_free_slot_finder
  import enemy_pkg::*;
#(
  parameter int SLOTS = 6
) (
  input  logic [SLOTS-1:0]  active,
  output logic [SLOT_W-1:0] free_idx,
  output logic              any_free
);
  // scan from the top so the lowest free index is the last one written
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) free_idx = active[i] ? free_idx : SLOT_W'(i);
  end
  assign any_free = ~&active;
endmodule

// File: rtl/enemy_slot_scheduler.sv
// enemy_slot_scheduler: enemy slot table with spawn/kill and per-frame fall/rotate walk (ENEMY_ROTATE_EN enables angle stepping)
module enemy_slot_scheduler
  import enemy_pkg::*;
#(
  parameter int SLOTS = 6,
  parameter int SCREEN_H = 480
`ifdef ENEMY_ROTATE_EN
  , parameter int ROT_PERIOD = 8
`endif
) (
  input logic clk,
  input logic rst,
  enemy_slot_scheduler_if.slave bus
);
  slot_t slots [SLOTS];
  state_t state;
  logic [SLOT_W-1:0] idx;
  logic [SLOTS-1:0] act;
  logic [SLOT_W-1:0] free_idx;
  logic any_free;
  logic fire;
  logic kill_hit;
  logic [POS_W:0] y_new;
`ifdef ENEMY_ROTATE_EN
  logic [7:0] fc;
  logic rot;
`endif
  for (genvar g = 0; g < SLOTS; g++) begin : g_flat
    assign act[g] = slots[g].active;
    assign bus.slot_type[TYPE_W*g +: TYPE_W] = slots[g].typ;
    assign bus.slot_angle[ANGLE_W*g +: ANGLE_W] = slots[g].angle;
    assign bus.slot_x[POS_W*g +: POS_W] = slots[g].x;
    assign bus.slot_y[POS_W*g +: POS_W] = slots[g].y;
  end
  assign bus.slot_active = act;
  enemy_free_slot_finder #(.SLOTS(SLOTS)) u_finder (
    .active(act),
    .free_idx(free_idx),
    .any_free(any_free)
  );
  assign bus.spawn_ready = (state == IDLE) && any_free;
  assign fire = bus.spawn_valid && bus.spawn_ready;
  assign kill_hit = bus.kill_valid && (int'(bus.kill_slot) < SLOTS) && act[bus.kill_slot];
  assign y_new = {1'b0, slots[idx].y} + (POS_W+1)'(slots[idx].typ) + (POS_W+1)'(1);
  // frame walk FSM plus spawn and kill writes; kill is applied last so it overrides the walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      bus.escape_pulse <= 1'b0;
      bus.escape_slot <= '0;
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
`ifdef ENEMY_ROTATE_EN
      fc <= '0;
      rot <= 1'b0;
`endif
    end else begin
      bus.escape_pulse <= 1'b0;
      if (state == IDLE) begin
        if (bus.frame_tick) begin
          state <= UPDATE;
          idx <= '0;
`ifdef ENEMY_ROTATE_EN
          rot <= fc == 8'(ROT_PERIOD - 1);
          fc <= fc == 8'(ROT_PERIOD - 1) ? '0 : fc + 8'd1;
`endif
        end
      end else begin
        if (slots[idx].active && !(kill_hit && bus.kill_slot == idx)) begin
`ifdef ENEMY_ROTATE_EN
          if (rot) slots[idx].angle <= slots[idx].angle == ANGLE_W'(ANGLE_AMOUNT - 1) ? '0 : slots[idx].angle + 1'b1;
`endif
          if (y_new > (POS_W+1)'(SCREEN_H - E_SIZE)) begin
            slots[idx].active <= 1'b0;
            bus.escape_pulse <= 1'b1;
            bus.escape_slot <= idx;
          end else begin
            slots[idx].y <= y_new[POS_W-1:0];
          end
        end
        state <= idx == SLOT_W'(SLOTS - 1) ? IDLE : UPDATE;
        idx <= idx == SLOT_W'(SLOTS - 1) ? '0 : idx + 1'b1;
      end
      if (fire) slots[free_idx] <= '{1'b1, bus.spawn_type, bus.spawn_angle, bus.spawn_x, bus.spawn_y};
      if (kill_hit) slots[bus.kill_slot].active <= 1'b0;
    end
  end
endmodule

// File: tb/tb_enemy_slot_scheduler.sv
// tb_enemy_slot_scheduler: directed scenarios plus random traffic against a slot-table reference model
module tb_enemy_slot_scheduler;
  localparam int SLOTS = 6;
  localparam int SCREEN_H = 480;
  localparam int E_SIZE = 36;
  localparam int ANGLE_AMOUNT = 16;
  localparam int ROT_PERIOD = 8;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_fail = 0;
  int esc_cnt = 0;
  enemy_slot_scheduler_if #(.SLOTS(SLOTS)) bus ();
  enemy_slot_scheduler #(.SLOTS(SLOTS), .SCREEN_H(SCREEN_H)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit m_act [SLOTS];
  int m_typ [SLOTS];
  int m_ang [SLOTS];
  int m_x [SLOTS];
  int m_y [SLOTS];
  int pend [$];
  int fc;
  bit rot;
  bit m_ep;
  int m_es;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < SLOTS; i++) begin
      m_act[i] = 0; m_typ[i] = 0; m_ang[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    pend.delete();
    fc = 0; rot = 0; m_ep = 0; m_es = 0;
  endtask
  function automatic int lowest_free();
    for (int i = 0; i < SLOTS; i++) if (!m_act[i]) return i;
    return -1;
  endfunction
  task automatic model_step();
    int f, k, ks, yn;
    bit take, tick, kill;
    f = lowest_free();
    take = bus.spawn_valid && pend.size() == 0 && f >= 0;
    tick = bus.frame_tick && pend.size() == 0;
    ks = int'(bus.kill_slot);
    kill = bus.kill_valid && ks < SLOTS && m_act[ks];
    m_ep = 0;
    if (pend.size() > 0) begin
      k = pend.pop_front();
      if (m_act[k] && !(kill && ks == k)) begin
`ifdef ENEMY_ROTATE_EN
        if (rot) m_ang[k] = (m_ang[k] + 1) % ANGLE_AMOUNT;
`endif
        yn = m_y[k] + m_typ[k] + 1;
        if (yn > SCREEN_H - E_SIZE) begin
          m_act[k] = 0; m_ep = 1; m_es = k;
        end else m_y[k] = yn;
      end
    end
    if (take) begin
      m_act[f] = 1; m_typ[f] = int'(bus.spawn_type); m_ang[f] = int'(bus.spawn_angle);
      m_x[f] = int'(bus.spawn_x); m_y[f] = int'(bus.spawn_y);
    end
    if (kill) m_act[ks] = 0;
    if (tick) begin
      rot = fc == ROT_PERIOD - 1;
      fc = (fc + 1) % ROT_PERIOD;
      for (int i = 0; i < SLOTS; i++) pend.push_back(i);
    end
  endtask
  task automatic compare_all();
    logic [63:0] ea, et, eg, ex, ey;
    ea = '0; et = '0; eg = '0; ex = '0; ey = '0;
    for (int i = 0; i < SLOTS; i++) begin
      ea[i] = m_act[i];
      et[2*i +: 2] = 2'(m_typ[i]);
      eg[4*i +: 4] = 4'(m_ang[i]);
      ex[10*i +: 10] = 10'(m_x[i]);
      ey[10*i +: 10] = 10'(m_y[i]);
    end
    chk("active", 64'(bus.slot_active), ea);
    chk("type", 64'(bus.slot_type), et);
    chk("angle", 64'(bus.slot_angle), eg);
    chk("x", 64'(bus.slot_x), ex);
    chk("y", 64'(bus.slot_y), ey);
    chk("escape_pulse", 64'(bus.escape_pulse), 64'(m_ep));
    chk("escape_slot", 64'(bus.escape_slot), 64'(m_es));
    chk("spawn_ready", 64'(bus.spawn_ready), 64'(pend.size() == 0 && lowest_free() >= 0));
  endtask
  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    if (bus.escape_pulse) esc_cnt++;
    compare_all();
  endtask
  task automatic clear_in();
    bus.frame_tick = 0; bus.spawn_valid = 0; bus.spawn_type = 0; bus.spawn_angle = 0;
    bus.spawn_x = 0; bus.spawn_y = 0; bus.kill_valid = 0; bus.kill_slot = 0;
  endtask
  task automatic spawn(int t, int a, int x, int y);
    bus.spawn_valid = 1; bus.spawn_type = 2'(t); bus.spawn_angle = 4'(a);
    bus.spawn_x = 10'(x); bus.spawn_y = 10'(y);
    step();
    bus.spawn_valid = 0;
  endtask
  task automatic frame();
    bus.frame_tick = 1;
    step();
    bus.frame_tick = 0;
    repeat (SLOTS + 1) step();
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    clear_in();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 0;
    #1;
    chk("ready_after_rst", 64'(bus.spawn_ready), 64'd1);
    bus.spawn_valid = 1;
    for (int i = 0; i < 7; i++) begin
      bus.spawn_type = 2'(i % 4); bus.spawn_angle = 4'(i);
      bus.spawn_x = 10'(10 * i); bus.spawn_y = 10'(20 * i);
      step();
    end
    chk("full_ready", 64'(bus.spawn_ready), 64'd0);
    chk("full_active", 64'(bus.slot_active), 64'h3f);
    bus.kill_valid = 1; bus.kill_slot = 3'd2; bus.spawn_type = 2'd1; bus.spawn_y = 10'd77;
    step();
    bus.kill_valid = 0;
    chk("kill_no_reuse", 64'(bus.slot_active), 64'h3b);
    step();
    bus.spawn_valid = 0;
    chk("refill_slot2", 64'(bus.slot_active), 64'h3f);
    chk("refill_y2", 64'(bus.slot_y[29:20]), 64'd77);
    for (int i = 0; i < SLOTS; i++) begin
      bus.kill_valid = 1; bus.kill_slot = 3'(i);
      step();
    end
    bus.kill_valid = 0;
    spawn(3, 5, 100, 440);
    frame();
    chk("y_444", 64'(bus.slot_y[9:0]), 64'd444);
    chk("still_active", 64'(bus.slot_active[0]), 64'd1);
    esc_cnt = 0;
    frame();
    chk("escape_count", 64'(esc_cnt), 64'd1);
    chk("escaped_inactive", 64'(bus.slot_active[0]), 64'd0);
    do_reset();
    spawn(0, 15, 50, 0);
    for (int f = 0; f < 7; f++) frame();
    chk("angle_pre_wrap", 64'(bus.slot_angle[3:0]), 64'd15);
    frame();
`ifdef ENEMY_ROTATE_EN
    chk("angle_wrap", 64'(bus.slot_angle[3:0]), 64'd0);
`else
    chk("angle_fixed", 64'(bus.slot_angle[3:0]), 64'd15);
`endif
    spawn(1, 2, 60, 100);
    esc_cnt = 0;
    bus.frame_tick = 1;
    step();
    bus.frame_tick = 0;
    step();
    bus.kill_valid = 1; bus.kill_slot = 3'd1;
    step();
    bus.kill_valid = 0;
    chk("kill_in_update", 64'(bus.slot_active[1]), 64'd0);
    chk("kill_no_escape", 64'(bus.escape_pulse), 64'd0);
    repeat (SLOTS) step();
    chk("kill_escape_count", 64'(esc_cnt), 64'd0);
    spawn(2, 3, 70, 200);
    bus.frame_tick = 1;
    step();
    bus.frame_tick = 0;
    repeat (3) step();
    do_reset();
    chk("rst_active", 64'(bus.slot_active), 64'd0);
    chk("rst_y", 64'(bus.slot_y), 64'd0);
    spawn(1, 1, 5, 10);
    bus.frame_tick = 1;
    step();
    bus.frame_tick = 0;
    chk("update_after_rst", 64'(bus.spawn_ready), 64'd0);
    repeat (SLOTS + 1) step();
    chk("y_after_rst_frame", 64'(bus.slot_y[9:0]), 64'd12);
    for (int c = 0; c < 1500; c++) begin
      bus.spawn_valid = 1'($urandom % 2);
      bus.spawn_type = 2'($urandom);
      bus.spawn_angle = 4'($urandom);
      bus.spawn_x = 10'($urandom_range(0, 639));
      bus.spawn_y = 10'($urandom_range(0, 460));
      bus.kill_valid = ($urandom % 4) == 0;
      bus.kill_slot = 3'($urandom);
      bus.frame_tick = ($urandom % 12) == 0;
      step();
    end
    clear_in();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
